mc_cpu: RTL and testbench
=========================

MC_CPU -- requirements
Module: mc_cpu

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, the pc value loaded on reset.
REQ-002 Parameter ADDR_W, 32, mem_addr width; the low ADDR_W bits of the 32-bit internal address are driven.
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 mem_req  out  1  memory request; held until accepted.
REQ-006 mem_we  out  1  1 = write (sw), 0 = read (fetch, lw); valid while mem_req=1.
REQ-007 mem_addr  out  ADDR_W  byte address; valid while mem_req=1.
REQ-008 mem_wdata  out  32  store data; valid while mem_req=1 and mem_we=1.
REQ-009 mem_rdata  in  32  read data; sampled on the edge where mem_req=1 and mem_ready=1.
REQ-010 mem_ready  in  1  accept/complete strobe; may be high in the same cycle mem_req rises (zero wait).
REQ-011 pc  out  32  current program counter.
REQ-012 state  out  3  FSM state: RST=0, IF=1, ID=2, EX=3, MEM=4, WB=5.
REQ-013 retire  out  1  one-cycle pulse in the last cycle of each instruction.

Function
REQ-014 Unified instruction/data memory port; one FSM; instructions execute in 3-5 states plus memory wait cycles.
REQ-015 Supported: add sub and or xor sll srl sra jr addi andi ori xori lui lw sw beq bne j jal; any other encoding executes as a NOP (IF->ID->IF, retire pulses).
REQ-016 RST -> IF unconditionally on the first edge after resetn rises.
REQ-017 IF: mem_req=1, mem_we=0, mem_addr=pc; on mem_ready, IR<=mem_rdata, pc<=pc+4, -> ID; otherwise stay in IF with outputs stable.
REQ-018 ID: A<=rf[rs], B<=rf[rt], ALUOut<=pc+(sext(imm)<<2); j/jal: pc<={pc[31:28],target,2'b00}, jal writes r31<=pc (already +4), -> IF; jr: pc<=rf[rs], -> IF; otherwise -> EX.
REQ-019 EX: beq/bne: pc<=ALUOut if taken, -> IF; R-type/immediate ALU ops: ALUOut<=result, -> WB; lw/sw: ALUOut<=A+sext(imm), -> MEM.
REQ-020 MEM: mem_req=1, mem_addr=ALUOut, mem_we=1 for sw with mem_wdata=B; on mem_ready, sw -> IF, lw latches MDR<=mem_rdata and -> WB.
REQ-021 WB: R-type writes rd, immediate ops write rt, lw writes rt with MDR; -> IF.
REQ-022 retire=1 in the state that transitions to IF (ID for jumps/NOP, EX for branches, MEM for sw, WB otherwise), and only on the edge that transitions.
REQ-023 Zero-wait latency in cycles: jump/NOP 2, branch 3, sw 4, ALU ops 4, lw 5; each wait cycle adds 1.
REQ-024 Arithmetic is 32-bit modulo 2^32; no overflow trap.
REQ-025 addi/lw/sw/beq/bne sign-extend imm; andi/ori/xori zero-extend; lui = imm<<16.
REQ-026 Shift amount = shamt[4:0]; sra replicates bit 31.
REQ-027 r0 reads 0; writes to r0 are discarded.
REQ-028 Register writes and the pc update occur only on the transitioning edge.
REQ-029 mem_req=0 in RST, ID, EX, and WB.
REQ-030 mem_addr, mem_we, and mem_wdata do not change while mem_req=1 and mem_ready=0.
REQ-031 pc wraps from 32'hFFFF_FFFC to 0.

Reset
REQ-032 resetn low asynchronously forces: state=RST, pc=RESET_PC, mem_req=0, mem_we=0, retire=0, and all 32 registers=0.
REQ-033 Reset asserted mid-request abandons the transaction immediately, and no register or memory write completes.
REQ-034 After resetn rises, the first fetch request appears one cycle later, at mem_addr=RESET_PC.

Verification
REQ-035 Reset release with ready tied high -> RST for 1 cycle, then IF with mem_addr=0; pc=4 after the fetch.
REQ-036 Program addi r1,r0,-1; addi r2,r0,1; add r3,r1,r2 -> r3=0, one retire pulse per instruction, 4 cycles each.
REQ-037 sw r1,8(r0) then lw r4,8(r0), with 3 wait cycles on every access -> write seen at addr 8 with data 32'hFFFFFFFF, r4=32'hFFFFFFFF, and the lw takes 5+3+3=11 cycles.
REQ-038 beq r0,r0,-1 at pc 0x10 -> branches to 0x10 forever with a retire every 3 cycles; bne r0,r0 -> falls through to 0x14.
REQ-039 jal 0x40 at pc 0x20 -> pc=0x100 and r31=0x24; then jr r31 -> pc=0x24.
REQ-040 resetn pulsed low during a MEM-state sw with mem_ready=0 -> mem_req drops in the same cycle, no write occurs, and the register contents read as 0 after restart.

Source files
------------

// File: rtl/mc_cpu.sv
`default_nettype none
// mc_cpu: multi-cycle MIPS-subset CPU with a single unified instruction/data memory port.
// Each instruction walks IF/ID/EX/MEM/WB as needed; unsupported encodings retire as NOPs.
module mc_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clock,
    input  logic              resetn,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc,
    output logic [2:0]        state,
    output logic              retire
);

    typedef enum logic [2:0] {
        ST_RST = 3'd0,
        ST_IF  = 3'd1,
        ST_ID  = 3'd2,
        ST_EX  = 3'd3,
        ST_MEM = 3'd4,
        ST_WB  = 3'd5
    } state_t;

    state_t      cur_state, nxt_state;
    logic [31:0] ir, a_reg, b_reg, alu_out, mdr;
    logic [31:0] rf [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] sext_imm, zext_imm, rs_val;
    logic        is_rtype, is_jr, is_imm, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_nop;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign shamt    = ir[10:6];
    assign funct    = ir[5:0];
    assign sext_imm = {{16{ir[15]}}, ir[15:0]};
    assign zext_imm = {16'h0000, ir[15:0]};
    assign rs_val   = rf[rs];

    assign is_rtype = (opcode == 6'h00) &&
                      (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03});
    assign is_jr    = (opcode == 6'h00) && (funct == 6'h08);
    assign is_imm   = opcode inside {6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    assign is_lw    = (opcode == 6'h23);
    assign is_sw    = (opcode == 6'h2B);
    assign is_beq   = (opcode == 6'h04);
    assign is_bne   = (opcode == 6'h05);
    assign is_j     = (opcode == 6'h02);
    assign is_jal   = (opcode == 6'h03);
    assign is_nop   = !(is_rtype || is_jr || is_imm || is_lw || is_sw ||
                        is_beq || is_bne || is_j || is_jal);

    logic [31:0] alu_result;
    always_comb begin
        alu_result = '0;
        if (opcode == 6'h00) begin
            case (funct)
                6'h20:   alu_result = a_reg + b_reg;
                6'h22:   alu_result = a_reg - b_reg;
                6'h24:   alu_result = a_reg & b_reg;
                6'h25:   alu_result = a_reg | b_reg;
                6'h26:   alu_result = a_reg ^ b_reg;
                6'h00:   alu_result = b_reg << shamt;
                6'h02:   alu_result = b_reg >> shamt;
                6'h03:   alu_result = $signed(b_reg) >>> shamt;
                default: alu_result = '0;
            endcase
        end else begin
            case (opcode)
                6'h08:   alu_result = a_reg + sext_imm;
                6'h0C:   alu_result = a_reg & zext_imm;
                6'h0D:   alu_result = a_reg | zext_imm;
                6'h0E:   alu_result = a_reg ^ zext_imm;
                6'h0F:   alu_result = {ir[15:0], 16'h0000};
                default: alu_result = '0;
            endcase
        end
    end

    logic [31:0] addr32, pc_nxt, alu_nxt, rf_wdata;
    logic [4:0]  rf_waddr;
    logic        ir_ld, pc_ld, alu_ld, mdr_ld, rf_we;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) cur_state <= ST_RST;
        else         cur_state <= nxt_state;
    end

    // Every architectural update below is gated to the edge that leaves the state.
    always_comb begin
        nxt_state = cur_state;
        retire    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr32    = pc;
        ir_ld     = 1'b0;
        pc_ld     = 1'b0;
        pc_nxt    = pc;
        alu_ld    = 1'b0;
        alu_nxt   = alu_out;
        mdr_ld    = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = rd;
        rf_wdata  = alu_out;
        case (cur_state)
            ST_RST: nxt_state = ST_IF;
            ST_IF: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_ld     = 1'b1;
                    pc_ld     = 1'b1;
                    pc_nxt    = pc + 32'd4;
                    nxt_state = ST_ID;
                end
            end
            ST_ID: begin
                alu_ld  = 1'b1;
                alu_nxt = pc + {sext_imm[29:0], 2'b00};
                if (is_j || is_jal) begin
                    pc_ld     = 1'b1;
                    pc_nxt    = {pc[31:28], ir[25:0], 2'b00};
                    rf_we     = is_jal;
                    rf_waddr  = 5'd31;
                    rf_wdata  = pc;
                    retire    = 1'b1;
                    nxt_state = ST_IF;
                end else if (is_jr) begin
                    pc_ld     = 1'b1;
                    pc_nxt    = rs_val;
                    retire    = 1'b1;
                    nxt_state = ST_IF;
                end else if (is_nop) begin
                    retire    = 1'b1;
                    nxt_state = ST_IF;
                end else begin
                    nxt_state = ST_EX;
                end
            end
            ST_EX: begin
                if (is_beq || is_bne) begin
                    pc_ld     = (a_reg == b_reg) ? is_beq : is_bne;
                    pc_nxt    = alu_out;
                    retire    = 1'b1;
                    nxt_state = ST_IF;
                end else if (is_lw || is_sw) begin
                    alu_ld    = 1'b1;
                    alu_nxt   = a_reg + sext_imm;
                    nxt_state = ST_MEM;
                end else begin
                    alu_ld    = 1'b1;
                    alu_nxt   = alu_result;
                    nxt_state = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_sw;
                addr32  = alu_out;
                if (mem_ready) begin
                    if (is_sw) begin
                        retire    = 1'b1;
                        nxt_state = ST_IF;
                    end else begin
                        mdr_ld    = 1'b1;
                        nxt_state = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we     = 1'b1;
                rf_waddr  = is_rtype ? rd : rt;
                rf_wdata  = is_lw ? mdr : alu_out;
                retire    = 1'b1;
                nxt_state = ST_IF;
            end
            default: nxt_state = ST_RST;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            if (ir_ld)  ir <= mem_rdata;
            if (pc_ld)  pc <= pc_nxt;
            if (cur_state == ST_ID) begin
                a_reg <= rs_val;
                b_reg <= rf[rt];
            end
            if (alu_ld) alu_out <= alu_nxt;
            if (mdr_ld) mdr     <= mem_rdata;
            if (rf_we && (rf_waddr != 5'd0)) rf[rf_waddr] <= rf_wdata;
        end
    end

    assign mem_addr  = addr32[ADDR_W-1:0];
    assign mem_wdata = b_reg;
    assign state     = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_cpu.sv
`default_nettype none
// tb_mc_cpu: scoreboard bench; an instruction-level model predicts bus traffic,
// retire latency and post-retire pc for directed and random programs.
module tb_mc_cpu;
    logic        clock = 1'b0;
    logic        resetn;
    logic        mem_req, mem_we, mem_ready, retire;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic [2:0]  state;

    logic [31:0] mem   [256];
    logic [31:0] m_mem [256];

    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } bus_t;
    typedef struct { logic [31:0] pc; int lat; } ret_t;
    bus_t exp_bus[$];
    ret_t exp_ret[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_ret;

    localparam logic [31:0] NOP_W = 32'hFC00_0000;

    always #5 clock = ~clock;
    assign mem_rdata = mem[mem_addr[9:2]];

    mc_cpu #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
        .clock(clock), .resetn(resetn), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .pc(pc), .state(state), .retire(retire)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction
    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    // Architectural model: executes n instructions and records the expected traffic.
    task automatic model_build(input int n);
        logic [31:0] rf_m [32];
        logic [31:0] mpc, ins, npc, rsv, rtv, simm, ea, wv;
        logic [4:0]  wa;
        logic        wr;
        int          lat;
        bus_t        b;
        ret_t        r;
        m_mem = mem;
        for (int i = 0; i < 32; i++) rf_m[i] = '0;
        mpc = 32'h0;
        for (int k = 0; k < n; k++) begin
            ins = m_mem[mpc[9:2]];
            b.we = 1'b0; b.addr = mpc; b.data = '0;
            exp_bus.push_back(b);
            npc  = mpc + 32'd4;
            rsv  = rf_m[ins[25:21]];
            rtv  = rf_m[ins[20:16]];
            simm = {{16{ins[15]}}, ins[15:0]};
            wr = 1'b0; wa = ins[20:16]; wv = '0; lat = 2;
            case (ins[31:26])
                6'h00: begin
                    wr = 1'b1; wa = ins[15:11]; lat = 4;
                    case (ins[5:0])
                        6'h20: wv = rsv + rtv;
                        6'h22: wv = rsv - rtv;
                        6'h24: wv = rsv & rtv;
                        6'h25: wv = rsv | rtv;
                        6'h26: wv = rsv ^ rtv;
                        6'h00: wv = rtv << ins[10:6];
                        6'h02: wv = rtv >> ins[10:6];
                        6'h03: wv = $signed(rtv) >>> ins[10:6];
                        6'h08: begin wr = 1'b0; lat = 2; npc = rsv; end
                        default: begin wr = 1'b0; lat = 2; end
                    endcase
                end
                6'h08: begin wr = 1'b1; lat = 4; wv = rsv + simm; end
                6'h0C: begin wr = 1'b1; lat = 4; wv = rsv & {16'h0, ins[15:0]}; end
                6'h0D: begin wr = 1'b1; lat = 4; wv = rsv | {16'h0, ins[15:0]}; end
                6'h0E: begin wr = 1'b1; lat = 4; wv = rsv ^ {16'h0, ins[15:0]}; end
                6'h0F: begin wr = 1'b1; lat = 4; wv = {ins[15:0], 16'h0}; end
                6'h23: begin
                    ea = rsv + simm; lat = 5;
                    b.we = 1'b0; b.addr = ea; b.data = '0;
                    exp_bus.push_back(b);
                    wr = 1'b1; wv = m_mem[ea[9:2]];
                end
                6'h2B: begin
                    ea = rsv + simm; lat = 4;
                    b.we = 1'b1; b.addr = ea; b.data = rtv;
                    exp_bus.push_back(b);
                    m_mem[ea[9:2]] = rtv;
                end
                6'h04: begin lat = 3; if (rsv == rtv) npc = mpc + 32'd4 + {simm[29:0], 2'b00}; end
                6'h05: begin lat = 3; if (rsv != rtv) npc = mpc + 32'd4 + {simm[29:0], 2'b00}; end
                6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
                6'h03: begin
                    npc = {npc[31:28], ins[25:0], 2'b00};
                    wr = 1'b1; wa = 5'd31; wv = mpc + 32'd4;
                end
                default: ;
            endcase
            if (wr && wa != 5'd0) rf_m[wa] = wv;
            r.pc = npc; r.lat = lat;
            exp_ret.push_back(r);
            mpc = npc;
        end
    endtask

    // policy: 0 always ready, 1 random, 2 three waits per access, 3 stall stores
    task automatic run_prog(input int n, input int policy);
        int cycles = 0;
        int wcnt   = 0;
        @(negedge clock);
        #1;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        exp_bus.delete();
        exp_ret.delete();
        model_build(n + 3);
        @(posedge clock);
        #1 resetn = 1'b1;
        #1;
        chk("rst_hold_state", {29'd0, state}, 32'd0);
        chk("rst_hold_req", {31'd0, mem_req}, 32'd0);
        while (n_ret < n && cycles < n * 40 + 50) begin
            @(negedge clock);
            cycles++;
            case (policy)
                0: mem_ready = 1'b1;
                1: mem_ready = ($urandom_range(0, 2) != 0);
                2: begin
                    if (mem_req && wcnt < 3) begin mem_ready = 1'b0; wcnt++; end
                    else begin mem_ready = 1'b1; wcnt = 0; end
                end
                default: mem_ready = !(mem_req && mem_we);
            endcase
            #1;
            if (mem_req && mem_ready && mem_we) mem[mem_addr[9:2]] = mem_wdata;
        end
        if (n_ret < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout retired=%0d required=%0d", n_ret, n);
        end
    endtask

    task automatic gen_random();
        logic [5:0]  rfn [8];
        logic [5:0]  ifn [5];
        logic [4:0]  ra, rb, rc;
        logic [15:0] imm, daddr;
        int          cls, off;
        rfn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03};
        ifn = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
        clear_mem();
        for (int i = 128; i < 144; i++) mem[i] = $urandom;
        for (int k = 0; k < 63; k++) begin
            cls   = $urandom_range(0, 9);
            ra    = 5'($urandom_range(0, 7));
            rb    = 5'($urandom_range(0, 7));
            rc    = 5'($urandom_range(0, 7));
            imm   = 16'($urandom);
            daddr = 16'(32'h200 + 4 * $urandom_range(0, 15));
            off   = $urandom_range(0, 3);
            if (off > 62 - k) off = 62 - k;
            case (cls)
                0, 1, 2: mem[k] = r_ins(rfn[$urandom_range(0, 7)], ra, rb, rc, 5'($urandom));
                3, 4:    mem[k] = i_ins(ifn[$urandom_range(0, 4)], ra, rb, imm);
                5:       mem[k] = i_ins(6'h23, 5'd0, rb, daddr);
                6:       mem[k] = i_ins(6'h2B, 5'd0, rb, daddr);
                7:       mem[k] = i_ins(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05, ra, rb, 16'(off));
                8:       mem[k] = j_ins(6'h02, 26'(k + 1 + off));
                default: mem[k] = ($urandom_range(0, 1) == 0) ? (NOP_W | 32'($urandom_range(0, 65535)))
                                                             : r_ins(6'h21, ra, rb, rc, 5'd0);
            endcase
        end
        mem[63] = j_ins(6'h02, 26'd0);
    endtask

    // Scoreboard monitor: samples mid-cycle, pops expectations as the DUT shows activity.
    logic        pend;
    logic [31:0] pend_pc;
    int          cyc, waits;
    always @(negedge clock) begin
        bus_t eb;
        ret_t er;
        #2;
        if (!resetn) begin
            pend = 1'b0; cyc = 0; waits = 0; n_ret = 0;
        end else begin
            if (pend) begin
                chk("pc_after_retire", pc, pend_pc);
                n_ret++;
                pend = 1'b0;
            end
            if (state != 3'd0) cyc++;
            if (mem_req && !mem_ready) waits++;
            if (mem_req && mem_ready) begin
                if (exp_bus.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL bus_unexpected addr=%h expected=none", mem_addr);
                end else begin
                    eb = exp_bus.pop_front();
                    chk("bus_we", {31'd0, mem_we}, {31'd0, eb.we});
                    chk("bus_addr", mem_addr, eb.addr);
                    if (eb.we) chk("bus_wdata", mem_wdata, eb.data);
                end
            end
            if (retire) begin
                if (exp_ret.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL retire_unexpected pc=%h expected=none", pc);
                end else begin
                    er = exp_ret.pop_front();
                    chk("retire_latency", 32'(cyc - waits), 32'(er.lat));
                    pend    = 1'b1;
                    pend_pc = er.pc;
                end
                cyc = 0; waits = 0;
            end
        end
    end

    initial begin
        resetn    = 1'b0;
        mem_ready = 1'b0;

        // addi/addi/add then store r3 so its value is visible on the bus
        clear_mem();
        mem[0] = i_ins(6'h08, 5'd0, 5'd1, 16'hFFFF);
        mem[1] = i_ins(6'h08, 5'd0, 5'd2, 16'h0001);
        mem[2] = r_ins(6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
        mem[3] = i_ins(6'h2B, 5'd0, 5'd3, 16'h0200);
        run_prog(4, 0);

        // store/load at byte 8 with three wait cycles on every access
        resetn = 1'b0;
        clear_mem();
        mem[0]  = i_ins(6'h08, 5'd0, 5'd1, 16'hFFFF);
        mem[1]  = j_ins(6'h02, 26'd16);
        mem[16] = i_ins(6'h2B, 5'd0, 5'd1, 16'h0008);
        mem[17] = i_ins(6'h23, 5'd0, 5'd4, 16'h0008);
        mem[18] = i_ins(6'h2B, 5'd0, 5'd4, 16'h000C);
        run_prog(5, 2);
        chk("mem_word8", mem[2], 32'hFFFF_FFFF);
        chk("mem_word12", mem[3], 32'hFFFF_FFFF);

        // beq r0,r0,-1 spinning at 0x10
        resetn = 1'b0;
        clear_mem();
        for (int i = 0; i < 4; i++) mem[i] = NOP_W;
        mem[4] = i_ins(6'h04, 5'd0, 5'd0, 16'hFFFF);
        run_prog(10, 0);

        // bne r0,r0,-1 falls through to 0x14
        resetn = 1'b0;
        mem[4] = i_ins(6'h05, 5'd0, 5'd0, 16'hFFFF);
        mem[5] = i_ins(6'h0F, 5'd0, 5'd5, 16'hABCD);
        mem[6] = i_ins(6'h2B, 5'd0, 5'd5, 16'h0200);
        run_prog(7, 1);

        // jal 0x40 at 0x20, then jr r31 back to 0x24
        resetn = 1'b0;
        clear_mem();
        for (int i = 0; i < 8; i++) mem[i] = NOP_W;
        mem[8]  = j_ins(6'h03, 26'h40);
        mem[9]  = NOP_W;
        mem[64] = i_ins(6'h2B, 5'd0, 5'd31, 16'h0200);
        mem[65] = r_ins(6'h08, 5'd31, 5'd0, 5'd0, 5'd0);
        run_prog(13, 1);

        // reset pulse while a store is stalled in MEM
        resetn = 1'b0;
        clear_mem();
        mem[0]  = i_ins(6'h08, 5'd0, 5'd1, 16'hFFFF);
        mem[1]  = i_ins(6'h2B, 5'd0, 5'd1, 16'h0080);
        mem[32] = 32'h1234_5678;
        run_prog(1, 3);
        for (int i = 0; i < 20 && !(mem_req && mem_we); i++) begin
            @(negedge clock);
            mem_ready = !(mem_req && mem_we);
            #1;
        end
        chk("sw_stalled", {30'd0, mem_req, mem_we}, 32'd3);
        #2 resetn = 1'b0;
        #1;
        chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
        chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
        chk("abort_state", {29'd0, state}, 32'd0);
        repeat (2) @(negedge clock);
        chk("abort_no_write", mem[32], 32'h1234_5678);
        mem[0] = i_ins(6'h2B, 5'd0, 5'd1, 16'h0084);
        mem[1] = i_ins(6'h2B, 5'd0, 5'd31, 16'h0088);
        run_prog(2, 0);

        // random programs against the model with random memory stalls
        for (int t = 0; t < 3; t++) begin
            resetn = 1'b0;
            gen_random();
            run_prog(150, 1);
        end

        resetn = 1'b0;
        #20;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
